// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: enables the ring, lets it settle, then counts
// synchronised ring rising edges over a 2**pGATE-cycle gate window.
module ring_freq_meter #(
    parameter int pSYNC   = 2,
    parameter int pSETTLE = 16,
    parameter int pGATE   = 10,
    parameter int pCW     = 12
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_cont,
    input  logic           i_ring,
    output logic           o_sel,
    output logic           o_busy,
    output logic           o_valid,
    output logic [pCW-1:0] o_count,
    output logic           o_ovf
);

    localparam int TW = ((pGATE > $clog2(pSETTLE)) ? pGATE : $clog2(pSETTLE)) + 1;
    localparam logic [TW-1:0]  SETTLE_END = TW'(pSETTLE - 1);
    localparam logic [TW-1:0]  GATE_END   = TW'((2 ** pGATE) - 1);
    localparam logic [pCW-1:0] CNT_MAX    = {pCW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [pSYNC-1:0] sync_r;
    logic           s_prev_r;
    logic           s_last_s;
    logic           rise_s;
    logic [TW-1:0]  timer_r, timer_nxt_s;
    logic [pCW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic           ovf_r, ovf_nxt_s, ovf_inc_s;
    logic           load_s;
    logic           sel_r, busy_r, valid_r, out_ovf_r;
    logic [pCW-1:0] out_count_r;

    assign s_last_s = sync_r[pSYNC-1];
    assign rise_s   = s_last_s & ~s_prev_r;

    // Saturating increment; ovf latches once the counter reaches all-ones.
    assign cnt_inc_s = (rise_s && (cnt_r != CNT_MAX)) ? (cnt_r + pCW'(1)) : cnt_r;
    assign ovf_inc_s = ovf_r | (cnt_inc_s == CNT_MAX);

    // Ring synchroniser and edge-detect history, running in every state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_r   <= {pSYNC{1'b0}};
            s_prev_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[pSYNC-2:0], i_ring};
            s_prev_r <= s_last_s;
        end
    end

    // Next-state, gate timer and edge counter control.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = ST_WARMUP;
                    timer_nxt_s = {TW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (timer_r == SETTLE_END) begin
                    state_nxt_s = ST_MEASURE;
                    timer_nxt_s = {TW{1'b0}};
                    cnt_nxt_s   = {pCW{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            ST_MEASURE: begin
                cnt_nxt_s = cnt_inc_s;
                ovf_nxt_s = ovf_inc_s;
                if (timer_r == GATE_END) begin
                    state_nxt_s = ST_DONE;
                    load_s      = 1'b1;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            ST_DONE: begin
                if (i_cont) begin
                    state_nxt_s = ST_MEASURE;
                    timer_nxt_s = {TW{1'b0}};
                    cnt_nxt_s   = {pCW{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, timer and counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= {TW{1'b0}};
            cnt_r   <= {pCW{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Output flops track the state being entered, so they match the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sel_r       <= 1'b0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            out_count_r <= {pCW{1'b0}};
            out_ovf_r   <= 1'b0;
        end else begin
            sel_r   <= (state_nxt_s != ST_IDLE);
            busy_r  <= (state_nxt_s != ST_IDLE);
            valid_r <= (state_nxt_s == ST_DONE);
            if (load_s) begin
                out_count_r <= cnt_inc_s;
                out_ovf_r   <= ovf_inc_s;
            end else begin
                out_count_r <= out_count_r;
                out_ovf_r   <= out_ovf_r;
            end
        end
    end

    assign o_sel   = sel_r;
    assign o_busy  = busy_r;
    assign o_valid = valid_r;
    assign o_count = out_count_r;
    assign o_ovf   = out_ovf_r;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed scoreboard bench for ring_freq_meter; a second instance with a
// 3-bit counter covers saturation. Periods divide the window, so counts are exact.
module tb_ring_freq_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, cont, ring;
    logic sel1, busy1, valid1, ovf1;
    logic [4:0] cnt1;
    logic sel2, busy2, valid2, ovf2;
    logic [2:0] cnt2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nval = 0;
    int period = 2;
    int ph = 0;
    int n0 = 0;
    logic [5:0] q1[$];
    logic [3:0] q2[$];

    ring_freq_meter #(.pSYNC(2), .pSETTLE(4), .pGATE(6), .pCW(5)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cont(cont), .i_ring(ring),
        .o_sel(sel1), .o_busy(busy1), .o_valid(valid1), .o_count(cnt1), .o_ovf(ovf1)
    );

    ring_freq_meter #(.pSYNC(2), .pSETTLE(4), .pGATE(6), .pCW(3)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cont(cont), .i_ring(ring),
        .o_sel(sel2), .o_busy(busy2), .o_valid(valid2), .o_count(cnt2), .o_ovf(ovf2)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid1) nval <= nval + 1;
    end

    // Free-running ring with a square wave of the current period.
    initial begin
        ring = 1'b0;
        forever begin
            @(negedge clk);
            ph = ph + 1;
            if (ph >= period) ph = 0;
            ring = (ph < period / 2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start sampled at the next posedge (edge n0); returns on the negedge after it.
    task automatic launch();
        start = 1'b1;
        n0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int t);
        logic [5:0] e1;
        logic [3:0] e2;
        int k;
        k = 0;
        t = 0;
        while (!valid1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!valid1) begin
            chk("valid_timeout", 32'd0, 32'd1);
        end else if (q1.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
            t = cyc;
            e1 = q1.pop_front();
            chk("count1", 32'(cnt1), 32'(e1[4:0]));
            chk("ovf1", 32'(ovf1), 32'(e1[5]));
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                chk("count2", 32'(cnt2), 32'(e2[2:0]));
                chk("ovf2", 32'(ovf2), 32'(e2[3]));
            end
            @(negedge clk);
            chk("valid_pulse", 32'(valid1), 32'd0);
        end
    endtask

    initial begin
        int t, t1, t2, v0;
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;

        // Reset with ring toggling
        idle(3);
        chk("rst_sel", 32'(sel1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_count", 32'(cnt1), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        rst_n = 1'b1;
        idle(20);
        chk("idle_busy", 32'(busy1), 32'd0);
        chk("idle_nval", 32'(nval), 32'd0);

        // Single measurement, period 8 -> 8 edges
        period = 8;
        idle(4);
        chk("pre_sel", 32'(sel1), 32'd0);
        q1.push_back({1'b0, 5'd8});
        launch();
        chk("start_sel", 32'(sel1), 32'd1);
        chk("start_busy", 32'(busy1), 32'd1);
        wait_valid(t);
        chk("single_lat", 32'(t - n0), 32'd68);
        chk("single_busy_low", 32'(busy1), 32'd0);
        chk("single_sel_low", 32'(sel1), 32'd0);

        // Saturation in the 3-bit instance, then a low-rate run
        period = 4;
        idle(4);
        q1.push_back({1'b0, 5'd16});
        q2.push_back({1'b1, 3'd7});
        launch();
        wait_valid(t);
        chk("sat_lat", 32'(t - n0), 32'd68);
        period = 32;
        idle(4);
        q1.push_back({1'b0, 5'd2});
        q2.push_back({1'b0, 3'd2});
        launch();
        wait_valid(t);

        // Continuous mode, period 16 -> 4 edges per window, 65-cycle cadence
        period = 16;
        idle(4);
        cont = 1'b1;
        repeat (3) q1.push_back({1'b0, 5'd4});
        launch();
        wait_valid(t1);
        chk("cont_lat", 32'(t1 - n0), 32'd68);
        chk("cont_busy", 32'(busy1), 32'd1);
        wait_valid(t2);
        chk("cont_gap1", 32'(t2 - t1), 32'd65);
        cont = 1'b0;
        wait_valid(t);
        chk("cont_gap2", 32'(t - t2), 32'd65);
        chk("cont_end_busy", 32'(busy1), 32'd0);

        // Abort by reset in mid-MEASURE
        period = 8;
        idle(4);
        launch();
        idle(30);
        chk("abort_busy", 32'(busy1), 32'd1);
        v0 = nval;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sel", 32'(sel1), 32'd0);
        chk("abort_count", 32'(cnt1), 32'd0);
        chk("abort_count2", 32'(cnt2), 32'd0);
        rst_n = 1'b1;
        idle(80);
        chk("abort_nval", 32'(nval - v0), 32'd0);
        q1.push_back({1'b0, 5'd8});
        launch();
        wait_valid(t);
        chk("restart_lat", 32'(t - n0), 32'd68);

        // i_start pulses during WARMUP and MEASURE are ignored
        idle(4);
        v0 = nval;
        q1.push_back({1'b0, 5'd8});
        launch();
        idle(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(t);
        chk("ign_lat", 32'(t - n0), 32'd68);
        idle(80);
        chk("ign_nval", 32'(nval - v0), 32'd1);
        chk("ign_busy", 32'(busy1), 32'd0);
        chk("queue_empty", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
- Downstream consumer of the ring-oscillator stage.
- Enables the ring through its select input, waits for it to settle, and synchronises the free-running ring output into the system clock domain.
- Counts ring rising edges over a fixed gate window of system clocks and presents the count as a frequency code.
- Valid when the ring frequency is below i_clk/2; the ring output is divided externally if necessary.

Parameters:
- pSYNC, 2, synchroniser depth for i_ring (minimum 2).
- pSETTLE, 16, i_clk cycles spent in WARMUP after the ring is enabled (minimum 1).
- pGATE, 10, gate window length is 2**pGATE i_clk cycles.
- pCW, 12, width of the edge counter and of o_count.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  level; sampled in IDLE, launches one measurement.
- i_cont  in  1  continuous mode; sampled in DONE.
- i_ring  in  1  asynchronous ring-oscillator output.
- o_sel  out  1  ring enable; drives the ring's select input (1 = run).
- o_busy  out  1  high in any state other than IDLE.
- o_valid  out  1  one-cycle pulse when o_count/o_ovf update.
- o_count  out  pCW  edge count of the last completed window.
- o_ovf  out  1  last window saturated the counter.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state=IDLE; o_sel, o_busy, o_valid, o_ovf = 0; o_count = 0.
  - Synchroniser chain, edge-detect register, gate timer and edge counter = 0.
  - Reset asserted mid-operation aborts immediately: o_sel drops the next cycle and no o_valid is produced.
- Synchroniser:
  - pSYNC flops, always running, including in IDLE.
  - rise = s_last & ~s_prev, where s_prev is s_last delayed one cycle.
- State machine (registered; outputs decoded from state):
  - IDLE: o_sel=0. i_start=1 -> WARMUP, timer cleared.
  - WARMUP: o_sel=1. Runs exactly pSETTLE cycles, then -> MEASURE with timer and edge counter cleared.
  - MEASURE: o_sel=1. Runs exactly 2**pGATE cycles. Every cycle with rise=1 increments the counter.
    - The counter saturates at 2**pCW-1 and sets the internal ovf flag; it never wraps.
  - DONE: single cycle; o_sel=1.
    - o_valid=1; o_count and o_ovf load the final counter and ovf values in this same cycle.
    - The rise in the last MEASURE cycle is included in the count.
    - i_cont=1 -> MEASURE directly, counter cleared, no re-warmup. Otherwise -> IDLE.
- Start timing: i_start high at edge N in IDLE -> o_sel/o_busy high from cycle N+1; o_valid at cycle N+1+pSETTLE+2**pGATE.
- i_start outside IDLE is ignored; it is not queued. i_start held high re-launches from IDLE after DONE.
- o_count and o_ovf hold their values until the next DONE or reset.
- o_valid is 0 in every state except DONE.
- i_cont changes take effect only when sampled in DONE; deasserting it ends the run at the next DONE.
- Edges arriving during IDLE or WARMUP are not counted.
  - The edge detector stays live, so a rise in the first MEASURE cycle counts only if s_prev=0 then.
- Counter width rule: the count is the true edge count clipped to pCW bits; ovf = (true count ≥ 2**pCW-1 reached).

Test Plan (bench params pSYNC=2, pSETTLE=4, pGATE=6, pCW=5 unless noted):
- Reset: hold i_rst_n=0 for 3 cycles with i_ring toggling -> all outputs 0. Release; no activity without i_start.
- Single measure: i_ring period 8 i_clk cycles, i_start pulse at edge N -> o_sel high N+1.
  - o_valid at N+69; o_count=8 (±1 depending on phase); o_ovf=0; o_busy low at N+70.
- Saturation: pCW=3, i_ring period 4 -> o_count=7, o_ovf=1. A following run with period 32 -> o_count=2, o_ovf=0.
- Continuous: i_cont=1, i_ring period 16 -> o_valid pulses every 65 cycles, each o_count=4, no WARMUP between windows.
  - Drop i_cont -> IDLE after the next DONE.
- Abort: assert i_rst_n=0 in mid-MEASURE -> o_sel=0 next cycle, no o_valid, o_count=0. Restart gives a correct result.
- Start ignored: i_start pulses during WARMUP/MEASURE -> exactly one o_valid, with timing unchanged.
